// File: rtl/shift_counter.sv
// Ring / Johnson shift counter with parallel load and ring self-correction; 1-cycle registered outputs.
// No backpressure: every enabled edge steps, and wrap/illegal are single-cycle pulses.
module shift_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic             wrap,
  output logic             illegal
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] home_cur;
  logic [WIDTH-1:0] home_new;

  assign home_cur = mode_q ? '0 : SEED;
  assign home_new = mode   ? '0 : SEED;

  // Ring rotates the end bit around; Johnson feeds back its complement.
  always_comb begin
    step_val = dout_q;
    if (!dir) begin
      step_val = {dout_q[WIDTH-2:0], dout_q[WIDTH-1] ^ mode_q};
    end else begin
      step_val = {dout_q[0] ^ mode_q, dout_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    dout_d    = dout_q;
    mode_d    = mode_q;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    if (load) begin
      dout_d = load_val;
    end else if (mode != mode_q) begin
      dout_d = home_new;
      mode_d = mode;
    end else if (en) begin
      if (!mode_q && !$onehot(dout_q)) begin
        dout_d    = SEED;
        illegal_d = 1'b1;
      end else begin
        dout_d = step_val;
        wrap_d = (step_val == home_cur);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= home_new;
      mode_q    <= mode;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      mode_q    <= mode_d;
      wrap_q    <= wrap_d;
      illegal_q <= illegal_d;
    end
  end

  assign dout    = dout_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_q;

endmodule

// File: doc/shift_counter.md
SHIFT_COUNTER -- requirements
Module: shift_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; SHALL be legal for any value >= 2.
REQ-002 Parameter SEED, default {WIDTH{1'b0}} | 1, ring-mode home state; SHALL be one-hot.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  step enable.
REQ-006 dir  input  1  direction: 0 = shift toward MSB, 1 = shift toward LSB.
REQ-007 mode  input  1  0 = ring counter, 1 = Johnson (twisted-ring) counter.
REQ-008 load  input  1  parallel load strobe.
REQ-009 load_val  input  WIDTH  value written on load.
REQ-010 dout  output  WIDTH  registered counter state.
REQ-011 wrap  output  1  registered one-cycle pulse on return to home state.
REQ-012 illegal  output  1  registered one-cycle pulse on ring-mode self-correction.

Function
REQ-013 Home state SHALL be SEED when mode=0 and all-zeros when mode=1.
REQ-014 Internal register mode_q SHALL hold the mode value last applied.
REQ-015 Per-edge priority SHALL be: rst > load > mode change (mode != mode_q) > en step > hold.
REQ-016 Load: dout <= load_val; no legality check; wrap=0, illegal=0 that cycle.
REQ-017 Mode change: dout <= home state of new mode; mode_q <= mode; wrap=0, illegal=0.
REQ-018 Ring step dir=0: dout <= {dout[WIDTH-2:0], dout[WIDTH-1]}; dir=1: dout <= {dout[0], dout[WIDTH-1:1]}.
REQ-019 Johnson step dir=0: dout <= {dout[WIDTH-2:0], ~dout[WIDTH-1]}; dir=1: dout <= {~dout[0], dout[WIDTH-1:1]}.
REQ-020 Ring-mode step with popcount(dout) != 1: dout <= SEED instead of rotating; illegal=1 next cycle; wrap=0.
REQ-021 Johnson mode: no legality check; illegal SHALL stay 0.
REQ-022 wrap SHALL be 1 in the cycle after any legal step whose next dout equals the home state; 0 otherwise.
REQ-023 Cycle period SHALL be WIDTH steps in ring mode and 2*WIDTH steps in Johnson mode, either direction.
REQ-024 en=0 (no load, no mode change): dout holds; wrap=0; illegal=0.
REQ-025 dir SHALL be sampled per step; a reversal mid-sequence SHALL take effect at the next step without extra latency.
REQ-026 load and en high together: load wins; no step that cycle.
REQ-027 mode change and en high together: mode change wins; no step that cycle.

Reset
REQ-028 rst=1 at an edge: dout <= home state of current mode input; mode_q <= mode; wrap <= 0; illegal <= 0.
REQ-029 rst SHALL override load, mode change and en in the same cycle, including mid-sequence.
REQ-030 dout, wrap and illegal SHALL be unknown-free from the first edge after reset.

Verification (WIDTH=4, SEED=0001)
REQ-031 mode=0, dir=0, rst then en=1 x4 -> dout 0010,0100,1000,0001; wrap=1 only after the 4th step.
REQ-032 mode=1, dir=0, rst then en=1 x8 -> 0001,0011,0111,1111,1110,1100,1000,0000; wrap=1 after the 8th step.
REQ-033 mode=0, load with load_val=0110, then en=1 -> dout 0110, then 0001 with illegal=1 one cycle; next step 0010.
REQ-034 mode=0 at 0100, dir=1, en=1 x2 -> 0010, 0001 with wrap=1; dir=0 next step -> 0010.
REQ-035 Counting at 1000 in mode 0, toggle mode to 1 with en=1 -> dout 0000, no step; next en -> 0001.
REQ-036 rst=1, load=1 and en=1 together at dout=0100 -> dout=0001, wrap=0, illegal=0.
